// File: rtl/noc_eject.sv
// -----------------------------------------------------------------------------
// noc_eject : ring-stop eject stage
//
// Registers the arbitrated flit stream. Valid flits whose destination field
// matches NODE_ID are removed into a local eject FIFO that drains to the core
// over a valid/ready handshake. Every other valid flit is forwarded unchanged
// to the next ring stop, and invalid flits are forwarded as all zeros. The
// ring cannot be stalled, so a hit arriving while the FIFO is full (and not
// popping) is dropped and flagged on the sticky overflow_o.
//
// Optional feature (macro NOC_EJECT_DROP_CNT_EN):
//   adds drop_cnt_o[15:0], a saturating count of dropped flits.
//
// Ports:
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous active-low reset
//   noc_i          in   flit from upstream arbiter (bit VALID_BIT_OFFSET = valid)
//   noc_o          out  flit to next ring stop (2-cycle latency)
//   core_o         out  eject FIFO head flit, zero when FIFO empty
//   core_valid_o   out  core_o holds a flit
//   core_rdy_i     in   core accepts core_o this cycle
//   almost_full_o  out  FIFO occupancy >= AFULL_THRESH
//   overflow_o     out  sticky: an ejected flit was dropped
//   drop_cnt_o     out  (NOC_EJECT_DROP_CNT_EN only) dropped-flit counter
// -----------------------------------------------------------------------------
module noc_eject #(
    parameter int                    DATA_WIDTH       = 65,
    parameter int                    VALID_BIT_OFFSET = 64,
    parameter int                    DEST_OFFSET      = 56,
    parameter int                    DEST_WIDTH       = 4,
    parameter logic [DEST_WIDTH-1:0] NODE_ID          = {DEST_WIDTH{1'b0}},
    parameter int                    BUF_DEPTH        = 16,
    parameter int                    LOG2_BUF_DEPTH   = 4,
    parameter int                    AFULL_THRESH     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] noc_i,
    output logic [DATA_WIDTH-1:0] noc_o,
    output logic [DATA_WIDTH-1:0] core_o,
    output logic                  core_valid_o,
    input  logic                  core_rdy_i,
    output logic                  almost_full_o,
    output logic                  overflow_o
`ifdef NOC_EJECT_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt_o
`endif
);

    localparam int CNT_W = LOG2_BUF_DEPTH + 1;

    localparam logic [CNT_W-1:0]          FULL_LVL  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0]          AFULL_LVL = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0]          CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]          CNT_ONE   = {{LOG2_BUF_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG2_BUF_DEPTH-1:0] PTR_ZERO  = {LOG2_BUF_DEPTH{1'b0}};
    localparam logic [LOG2_BUF_DEPTH-1:0] PTR_ONE   = {{(LOG2_BUF_DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]     FLIT_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0]     in_r;
    logic [DATA_WIDTH-1:0]     mem_r [BUF_DEPTH];
    logic [LOG2_BUF_DEPTH-1:0] wr_ptr_r;
    logic [LOG2_BUF_DEPTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic                      overflow_r;

    logic                      hit_s;
    logic                      full_s;
    logic                      valid_s;
    logic                      pop_s;
    logic                      push_s;
    logic                      drop_s;
    logic [DATA_WIDTH-1:0]     fwd_s;
    logic [DATA_WIDTH-1:0]     head_s;
    logic [CNT_W-1:0]          count_nxt_s;

    // Hit decode, FIFO handshake terms and forward-path data selection.
    always_comb begin
        hit_s   = in_r[VALID_BIT_OFFSET] &&
                  (in_r[DEST_OFFSET +: DEST_WIDTH] == NODE_ID);
        full_s  = (count_r == FULL_LVL);
        valid_s = (count_r != CNT_ZERO);
        pop_s   = valid_s && core_rdy_i;
        // When full, a simultaneous pop frees the slot the push overwrites;
        // the popped head is consumed on the same edge the new flit lands.
        push_s  = hit_s && (!full_s || pop_s);
        drop_s  = hit_s && full_s && !pop_s;

        if (in_r[VALID_BIT_OFFSET] && !hit_s) begin
            fwd_s = in_r;
        end else begin
            fwd_s = FLIT_ZERO;
        end

        // Stale RAM contents are never exposed to the core.
        if (valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = FLIT_ZERO;
        end
    end

    // Occupancy next-state: push and pop together leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pipeline registers, FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_r       <= FLIT_ZERO;
            noc_o      <= FLIT_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            in_r    <= noc_i;
            noc_o   <= fwd_s;
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by count_r, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_r;
        end
    end

    assign core_o        = head_s;
    assign core_valid_o  = valid_s;
    assign almost_full_o = (count_r >= AFULL_LVL);
    assign overflow_o    = overflow_r;

`ifdef NOC_EJECT_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of flits lost to eject overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_noc_eject.sv
// -----------------------------------------------------------------------------
// Self-checking bench for noc_eject (default parameters, NODE_ID = 0).
// A reference model (forward scoreboard queue + eject FIFO queue) is updated
// as stimulus is driven; DUT outputs are compared 1 time unit after each
// rising edge. Scenario tasks add their own targeted checks.
// -----------------------------------------------------------------------------
module tb_noc_eject;

    localparam int DW = 65;

    logic          clk;
    logic          rst;
    logic [DW-1:0] noc_i;
    logic [DW-1:0] noc_o;
    logic [DW-1:0] core_o;
    logic          core_valid_o;
    logic          core_rdy_i;
    logic          almost_full_o;
    logic          overflow_o;
`ifdef NOC_EJECT_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    int checks;
    int errors;

    // Reference model state.
    logic [DW-1:0] fwd_q   [$];
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] stage_m;
    logic          ovf_m;
    int            drops_m;

    noc_eject dut (
        .clk           (clk),
        .rst           (rst),
        .noc_i         (noc_i),
        .noc_o         (noc_o),
        .core_o        (core_o),
        .core_valid_o  (core_valid_o),
        .core_rdy_i    (core_rdy_i),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o)
`ifdef NOC_EJECT_DROP_CNT_EN
        ,
        .drop_cnt_o    (drop_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mk(input logic v, input logic [3:0] dest,
                                         input logic [55:0] payload);
        return {v, 4'hA, dest, payload};
    endfunction

    task automatic model_reset();
        fwd_q.delete();
        model_q.delete();
        fwd_q.push_back({DW{1'b0}});
        stage_m = {DW{1'b0}};
        ovf_m   = 1'b0;
        drops_m = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, compare after the edge.
    task automatic step(input logic [DW-1:0] flit, input logic rdy);
        int            sz;
        logic          pop_m;
        logic          hit_m;
        logic [DW-1:0] tmp;
        logic [DW-1:0] exp_fwd;
        logic [DW-1:0] exp_core;
        noc_i      = flit;
        core_rdy_i = rdy;
        fwd_q.push_back((flit[64] && flit[59:56] != 4'd0) ? flit : {DW{1'b0}});
        sz    = model_q.size();
        pop_m = (sz != 0) && rdy;
        hit_m = stage_m[64] && (stage_m[59:56] == 4'd0);
        if (pop_m) tmp = model_q.pop_front();
        if (hit_m) begin
            if (sz < 16 || pop_m) begin
                model_q.push_back(stage_m);
            end else begin
                drops_m++;
                ovf_m = 1'b1;
            end
        end
        stage_m = flit;
        @(posedge clk);
        #1;
        exp_fwd  = fwd_q.pop_front();
        exp_core = (model_q.size() != 0) ? model_q[0] : {DW{1'b0}};
        checks++;
        if (noc_o !== exp_fwd) begin
            errors++;
            $display("FAIL noc_o: got %h expected %h at %0t", noc_o, exp_fwd, $time);
        end
        checks++;
        if (core_valid_o !== (model_q.size() != 0)) begin
            errors++;
            $display("FAIL core_valid_o: got %b expected %b at %0t", core_valid_o,
                     (model_q.size() != 0), $time);
        end
        checks++;
        if (core_o !== exp_core) begin
            errors++;
            $display("FAIL core_o: got %h expected %h at %0t", core_o, exp_core, $time);
        end
        checks++;
        if (almost_full_o !== (model_q.size() >= 12)) begin
            errors++;
            $display("FAIL almost_full_o: got %b expected %b (occ %0d) at %0t",
                     almost_full_o, (model_q.size() >= 12), model_q.size(), $time);
        end
        checks++;
        if (overflow_o !== ovf_m) begin
            errors++;
            $display("FAIL overflow_o: got %b expected %b at %0t", overflow_o, ovf_m, $time);
        end
`ifdef NOC_EJECT_DROP_CNT_EN
        checks++;
        if (drop_cnt_o !== 16'(drops_m)) begin
            errors++;
            $display("FAIL drop_cnt_o: got %0d expected %0d at %0t", drop_cnt_o, drops_m, $time);
        end
`endif
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step({DW{1'b0}}, rdy);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        noc_i      = mk(1'b1, 4'd3, 56'hDEAD);
        core_rdy_i = 1'b0;
        #3;
        checks++;
        if (noc_o !== {DW{1'b0}} || core_valid_o !== 1'b0 || core_o !== {DW{1'b0}} ||
            almost_full_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: noc_o=%h core_valid_o=%b core_o=%h af=%b ovf=%b expected all 0",
                     noc_o, core_valid_o, core_o, almost_full_o, overflow_o);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (noc_o !== {DW{1'b0}} || core_valid_o !== 1'b0 || core_o !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL reset_hold: noc_o=%h core_valid_o=%b core_o=%h expected 0",
                     noc_o, core_valid_o, core_o);
        end
        noc_i = {DW{1'b0}};
        rst   = 1'b1;
        model_reset();
        idle(2, 1'b0);
    endtask

    task automatic test_forward();
        for (int i = 0; i < 5; i++) begin
            step(mk(1'b1, 4'd3, 56'h100 + 56'(i)), 1'b0);
            checks++;
            if (core_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL fwd_no_eject: core_valid_o=%b expected 0", core_valid_o);
            end
        end
        idle(3, 1'b0);
    endtask

    task automatic test_eject();
        int hi;
        hi = 0;
        step(mk(1'b1, 4'd0, 56'h1234), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step({DW{1'b0}}, 1'b1);
            if (core_valid_o === 1'b1) hi++;
        end
        checks++;
        if (hi != 1) begin
            errors++;
            $display("FAIL eject_one_cycle: core_valid_o high %0d cycles, expected 1", hi);
        end
    endtask

    task automatic test_afull_drain();
        for (int i = 0; i < 12; i++) step(mk(1'b1, 4'd0, 56'h200 + 56'(i)), 1'b0);
        checks++;
        if (almost_full_o !== 1'b0) begin
            errors++;
            $display("FAIL afull_early: almost_full_o=%b expected 0 with 11 stored", almost_full_o);
        end
        step({DW{1'b0}}, 1'b0);
        checks++;
        if (almost_full_o !== 1'b1) begin
            errors++;
            $display("FAIL afull_rise: almost_full_o=%b expected 1 with 12 stored", almost_full_o);
        end
        for (int i = 12; i < 16; i++) step(mk(1'b1, 4'd0, 56'h200 + 56'(i)), 1'b0);
        idle(3, 1'b0);
        checks++;
        if (core_o !== mk(1'b1, 4'd0, 56'h200) || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full16_head: core_o=%h ovf=%b expected head payload 200, ovf 0",
                     core_o, overflow_o);
        end
        idle(18, 1'b1);
        checks++;
        if (core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: core_valid_o=%b expected 0", core_valid_o);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) step(mk(1'b1, 4'd0, 56'h300 + 56'(i)), 1'b0);
        idle(2, 1'b0);
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: overflow_o=%b expected 1", overflow_o);
        end
`ifdef NOC_EJECT_DROP_CNT_EN
        checks++;
        if (drop_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL drop_cnt_two: drop_cnt_o=%0d expected 2", drop_cnt_o);
        end
`endif
        // Hit lands on the same edge as a pop while full: accepted.
        step(mk(1'b1, 4'd0, 56'h3AA), 1'b0);
        step({DW{1'b0}}, 1'b1);
        step({DW{1'b0}}, 1'b0);
        checks++;
        if (core_o !== mk(1'b1, 4'd0, 56'h301) || almost_full_o !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: core_o=%h af=%b expected payload 301, af 1",
                     core_o, almost_full_o);
        end
        idle(18, 1'b1);
        checks++;
        if (overflow_o !== 1'b1 || core_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b core_valid_o=%b expected 1, 0",
                     overflow_o, core_valid_o);
        end
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 12; i++) begin
            step(mk(1'b1, (i % 2 == 0) ? 4'd0 : 4'd5, 56'h400 + 56'(i)),
                 1'($urandom_range(0, 1)));
        end
        step(mk(1'b0, 4'd0, 56'hBEEF), 1'b0);
        step(mk(1'b0, 4'd5, 56'hCAFE), 1'b1);
        idle(10, 1'b1);
    endtask

    task automatic test_reset_midtraffic();
        step(mk(1'b1, 4'd0, 56'h501), 1'b0);
        step(mk(1'b1, 4'd0, 56'h502), 1'b0);
        step(mk(1'b1, 4'd0, 56'h503), 1'b0);
        step(mk(1'b1, 4'd3, 56'h504), 1'b0);
        step(mk(1'b1, 4'd0, 56'h505), 1'b0);
        rst = 1'b0;
        #2;
        checks++;
        if (noc_o !== {DW{1'b0}} || core_valid_o !== 1'b0 || core_o !== {DW{1'b0}} ||
            almost_full_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: noc_o=%h core_valid_o=%b core_o=%h af=%b ovf=%b expected all 0",
                     noc_o, core_valid_o, core_o, almost_full_o, overflow_o);
        end
`ifdef NOC_EJECT_DROP_CNT_EN
        checks++;
        if (drop_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: drop_cnt_o=%0d expected 0", drop_cnt_o);
        end
`endif
        noc_i = mk(1'b1, 4'd0, 56'h5FF);
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (core_valid_o !== 1'b0 || noc_o !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL reset_held: core_valid_o=%b noc_o=%h expected 0", core_valid_o, noc_o);
        end
        noc_i = {DW{1'b0}};
        rst   = 1'b1;
        model_reset();
        // Pointers restart at zero: new flits come out in order.
        step(mk(1'b1, 4'd0, 56'h601), 1'b0);
        step(mk(1'b1, 4'd0, 56'h602), 1'b0);
        idle(2, 1'b0);
        checks++;
        if (core_o !== mk(1'b1, 4'd0, 56'h601)) begin
            errors++;
            $display("FAIL reset_restart: core_o=%h expected payload 601", core_o);
        end
        idle(4, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_forward();
        test_eject();
        test_afull_drain();
        test_overflow();
        test_mixed();
        test_reset_midtraffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
